// File: rtl/id_pkg.sv
// Shared identifier definitions: character classes and run-tracker state
// encoding. The matcher uses the same classifiers, so the two cannot diverge.
package id_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } trk_state_e;

    // True for 'a'..'z' or 'A'..'Z'
    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7a)) || ((c >= 8'h41) && (c <= 8'h5a));
    endfunction

    // True for '0'..'9'
    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] out
);

    localparam logic [W-1:0] MAX_C = {W{1'b1}};
    localparam logic [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;

    // Count register: reset, clear, saturating increment, else hold
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign out = cnt_r;

endmodule

// File: rtl/id_token_stat.sv
// Identifier token statistics: tracks letter-led alphanumeric runs alongside
// the matcher and reports completed tokens (pulse, length, count, longest).
module id_token_stat
    import id_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic             match,
    input  logic             clear,
    output logic             tok_done,
    output logic [LEN_W-1:0] tok_len,
    output logic [CNT_W-1:0] tok_count,
    output logic [LEN_W-1:0] max_len
);

    trk_state_e       state_r;
    trk_state_e       state_nxt_s;
    logic             char_let_s;
    logic             char_dig_s;
    logic             char_sep_s;
    logic             run_inc_s;
    logic             run_clr_s;
    logic [LEN_W-1:0] run_len_s;
    logic             complete_s;
    logic             tok_done_r;
    logic [LEN_W-1:0] tok_len_r;
    logic [LEN_W-1:0] max_len_r;
    logic [CNT_W-1:0] tok_count_s;

    assign char_let_s = is_letter(char);
    assign char_dig_s = is_digit(char);
    assign char_sep_s = !(char_let_s || char_dig_s);

    // Run tracker state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Run tracker next state and run-length counter control
    always_comb begin
        state_nxt_s = state_r;
        run_inc_s   = 1'b0;
        run_clr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (char_let_s) begin
                    state_nxt_s = RUN;
                    run_inc_s   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    run_clr_s   = 1'b1;
                end
            end
            RUN: begin
                if (char_sep_s) begin
                    state_nxt_s = IDLE;
                    run_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                    run_inc_s   = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                run_clr_s   = 1'b1;
            end
        endcase
    end

    sat_counter #(.W(LEN_W)) u_run_len (
        .clk   (clk),
        .reset (reset),
        .inc   (run_inc_s),
        .clr   (run_clr_s),
        .out   (run_len_s)
    );

    // A token ends when a separator arrives mid-run with match asserted;
    // stale match while idle (matcher not reset) is ignored here.
    assign complete_s = match && char_sep_s && (state_r == RUN) &&
                        (run_len_s != {LEN_W{1'b0}});

    sat_counter #(.W(CNT_W)) u_tok_count (
        .clk   (clk),
        .reset (reset),
        .inc   (complete_s),
        .clr   (clear),
        .out   (tok_count_s)
    );

    // Registered completion pulse, last length and longest length;
    // clear overrides a same-cycle max update but not the pulse/length
    always_ff @(posedge clk) begin
        if (reset) begin
            tok_done_r <= 1'b0;
            tok_len_r  <= {LEN_W{1'b0}};
            max_len_r  <= {LEN_W{1'b0}};
        end else begin
            tok_done_r <= complete_s;
            if (complete_s) begin
                tok_len_r <= run_len_s;
            end else begin
                tok_len_r <= tok_len_r;
            end
            if (clear) begin
                max_len_r <= {LEN_W{1'b0}};
            end else if (complete_s && (run_len_s > max_len_r)) begin
                max_len_r <= run_len_s;
            end else begin
                max_len_r <= max_len_r;
            end
        end
    end

    assign tok_done  = tok_done_r;
    assign tok_len   = tok_len_r;
    assign tok_count = tok_count_s;
    assign max_len   = max_len_r;

endmodule

// File: tb/tb_id_token_stat.sv
// Scoreboard bench for id_token_stat: a default-width instance and a narrow
// (LEN_W=3, CNT_W=4) instance share one directed character stream.
module tb_id_token_stat;

    typedef struct {
        int len;
        int cnt;
        int mx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        match;
    logic [7:0]  char;

    logic        a_done;
    logic [7:0]  a_len;
    logic [15:0] a_cnt;
    logic [7:0]  a_max;
    logic        b_done;
    logic [2:0]  b_len;
    logic [3:0]  b_cnt;
    logic [2:0]  b_max;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    // reference matcher state: 0 none, 1 letter run, 2 letters then digits
    int   mstate      = 0;
    bit   force_match = 1'b0;

    always #5 clk = ~clk;

    id_token_stat dut_a (
        .clk       (clk),
        .reset     (reset),
        .char      (char),
        .match     (match),
        .clear     (clear),
        .tok_done  (a_done),
        .tok_len   (a_len),
        .tok_count (a_cnt),
        .max_len   (a_max)
    );

    id_token_stat #(.CNT_W(4), .LEN_W(3)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .char      (char),
        .match     (match),
        .clear     (clear),
        .tok_done  (b_done),
        .tok_len   (b_len),
        .tok_count (b_cnt),
        .max_len   (b_max)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int cls(input logic [7:0] c);
        if ((c >= 8'h61 && c <= 8'h7a) || (c >= 8'h41 && c <= 8'h5a)) return 1;
        if (c >= 8'h30 && c <= 8'h39) return 2;
        return 0;
    endfunction

    // present one char; match reflects the chars of earlier cycles
    task automatic send(input logic [7:0] c, input bit clr, input bit rst);
        int k;
        @(posedge clk);
        #1;
        char  = c;
        clear = clr;
        reset = rst;
        match = force_match ? 1'b1 : (mstate == 2);
        k = cls(c);
        if (k == 1) mstate = 1;
        else if (k == 2) mstate = (mstate != 0) ? 2 : 0;
        else mstate = 0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b0, 1'b0);
    endtask

    task automatic push(input int la, input int ca, input int ma,
                        input int lb, input int cb, input int mb);
        exp_t e;
        e.len = la; e.cnt = ca; e.mx = ma; qa.push_back(e);
        e.len = lb; e.cnt = cb; e.mx = mb; qb.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_a_done"}, int'(a_done), 0);
        check({tag, "_a_len"},  int'(a_len),  0);
        check({tag, "_a_cnt"},  int'(a_cnt),  0);
        check({tag, "_a_max"},  int'(a_max),  0);
        check({tag, "_b_done"}, int'(b_done), 0);
        check({tag, "_b_len"},  int'(b_len),  0);
        check({tag, "_b_cnt"},  int'(b_cnt),  0);
        check({tag, "_b_max"},  int'(b_max),  0);
    endtask

    // monitor for the default-width instance
    always @(negedge clk) begin
        if (a_done === 1'b1) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_done: got pulse, expected none (len %0d)", a_len);
            end else begin
                ea = qa.pop_front();
                check("a_tok_len",   int'(a_len), ea.len);
                check("a_tok_count", int'(a_cnt), ea.cnt);
                check("a_max_len",   int'(a_max), ea.mx);
            end
        end
    end

    // monitor for the narrow instance
    always @(negedge clk) begin
        if (b_done === 1'b1) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_done: got pulse, expected none (len %0d)", b_len);
            end else begin
                eb = qb.pop_front();
                check("b_tok_len",   int'(b_len), eb.len);
                check("b_tok_count", int'(b_cnt), eb.cnt);
                check("b_max_len",   int'(b_max), eb.mx);
            end
        end
    end

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        match = 1'b1;
        char  = 8'h20;

        // stale match from an unreset matcher, then a separator while idle
        force_match = 1'b1;
        send(8'h20, 1'b0, 1'b1);
        send(8'h20, 1'b0, 1'b1);
        @(negedge clk);
        check("rst_a_done", int'(a_done), 0);
        check("rst_a_len",  int'(a_len),  0);
        check("rst_a_cnt",  int'(a_cnt),  0);
        check("rst_a_max",  int'(a_max),  0);
        send(8'h20, 1'b0, 1'b0);
        check_idle("stale");
        force_match = 1'b0;

        // basic token
        push(4, 1, 4, 4, 1, 4);
        send_str("ab12 ");

        // letters after digits continue the identifier
        send(8'h20, 1'b0, 1'b1);
        push(5, 1, 5, 5, 1, 5);
        send_str("ab1c2;");

        // non-identifiers, then back-to-back tokens
        send(8'h20, 1'b0, 1'b1);
        send_str("12ab abc ");
        push(2, 1, 2, 2, 1, 2);
        push(3, 2, 3, 3, 2, 3);
        send_str("x9 y77 ");

        // reset in the middle of a token abandons it
        send(8'h20, 1'b0, 1'b1);
        send_str("ab1");
        send("2", 1'b0, 1'b1);
        send(8'h20, 1'b0, 1'b0);
        check_idle("midrst");

        // long token saturates the narrow length; then clear on a completion
        send(8'h20, 1'b0, 1'b1);
        push(10, 1, 10, 7, 1, 7);
        send_str("a123456789 ");
        push(2, 0, 0, 2, 0, 0);
        send_str("b1");
        send(8'h20, 1'b1, 1'b0);
        send(8'h20, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        check("a_final_count", int'(a_cnt), 0);
        check("b_final_len",   int'(b_len), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
